mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares one single-ported unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage MIPS pipeline. It serialises the requests and drives a variable-latency memory handshake. It also generates the pipeline `stall` while any request is outstanding, and flags a sticky `err` on memory timeout. It sits between the IF/MEM stage logic and the memory model, and replaces the separate instruction and data memory paths.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while fetch waits; the next contested grant then goes to fetch.
- `TIMEOUT`, default 255: BUSY cycles without `mem_ack` before the access is aborted.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `if_req` in 1: fetch request, held until `if_rvalid`.
- `if_addr` in 32: fetch word address, stable while `if_req` is high.
- `if_rvalid` out 1: one-cycle fetch completion pulse.
- `if_rdata` out 32: fetch data, valid with `if_rvalid`.
- `dm_req` in 1: data request, held until `dm_rvalid`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in 32: data address.
- `dm_wdata` in 32: store data.
- `dm_rvalid` out 1: one-cycle data completion pulse (loads and stores).
- `dm_rdata` out 32: load data; 0 for stores.
- `mem_req` out 1: memory access strobe, registered.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_ack` in 1: memory completion; may be high in the first `mem_req` cycle.
- `mem_rdata` in 32: memory read data, valid with `mem_ack`.
- `stall` out 1: pipeline stall request.
- `err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, BUSY, RESP. A `owner` register records which requester holds the grant (IF or DM).
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant DM, unless `starve_cnt == STARVE_LIMIT`, in which case grant IF.
  - On a grant: latch address, write enable and write data into the `mem_*` registers, set `mem_req`, go to BUSY.
- **BUSY**
  - On `mem_ack`: capture `mem_rdata` (or 0 for a store), drop `mem_req`, go to RESP.
  - If `wait_cnt` reaches `TIMEOUT` with no ack: set `err`, set the response data to 0, drop `mem_req`, go to RESP.
- **RESP**: pulse the owner's `rvalid` for one cycle, then go to IDLE unconditionally.
- The requester may drop `req` or present a new request in the cycle after its `rvalid`. The arbiter never samples `req` in the RESP cycle.
- `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`):
  - increments, saturating, on each DM grant made while `if_req` is high;
  - clears on any IF grant.
- `wait_cnt` (8 bits at the default `TIMEOUT`): cleared on entry to BUSY, increments each BUSY cycle.
- `stall = (if_req & ~if_rvalid) | (dm_req & ~dm_rvalid)`. This is combinational from the inputs and the registered `rvalid` outputs.
- `err` remains set until reset. A timed-out access still completes normally through RESP.
- **Reset (asynchronous, including mid-access)**:
  - state = IDLE, `mem_req` = 0 immediately;
  - all outputs, counters and data registers = 0, `err` = 0.
  - An in-flight access is dropped with no `rvalid`.

## Timing
- Minimum latency:
  - request in cycle 0 → `mem_req` high in cycle 1;
  - `mem_ack` in cycle 1 → `rvalid` in cycle 2.
- Maximum latency: 2 + `TIMEOUT` cycles plus any arbitration wait.
- Back-to-back throughput: one access per 3 cycles (IDLE, BUSY, RESP).
- `mem_addr`, `mem_we` and `mem_wdata` are constant for as long as `mem_req` is high.
- `mem_ack` while `mem_req` is low is ignored.
- `rvalid` and `rdata` are registered outputs and change only on `clk`.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, BUSY, RESP};
  - `arb_owner_t` enum {OWN_IF, OWN_DM};
  - localparam `WORD_W = 32`.
- One natural sub-module, `mem_arb_timeout`: the `wait_cnt` counter with clear/enable inputs and an `expired` output.
- Priority selection and the FSM stay in the top module.

## Test plan
- **Single fetch.** Stimulus: `if_req`, `if_addr = 0x1000`, memory acks immediately with `0x2402000A`. Required: `mem_req` and `mem_addr = 0x1000` in cycle 1; `if_rvalid` with `if_rdata = 0x2402000A` in cycle 2; `stall` high in cycles 0–1 and low in cycle 2.
- **Contested request.** Stimulus: `if_req` and `dm_req` (load, `0x2000`) both raised in cycle 0. Required: DM is served first (`mem_addr = 0x2000`, `dm_rvalid` in cycle 2); the IF access then starts, with `mem_addr = 0x1000` in cycle 4.
- **Starvation guard.** Stimulus: `dm_req` held continuously while `if_req` stays pending. Required: exactly 4 DM completions, then the IF grant; `starve_cnt` reads 0 after the IF grant.
- **Store.** Stimulus: `dm_we = 1`, `dm_addr = 0x2004`, `dm_wdata = 0xDEADBEEF`, memory acks after 3 cycles. Required: `mem_we = 1` and `mem_wdata = 0xDEADBEEF` held for all 3 cycles; `dm_rvalid` with `dm_rdata = 0`.
- **Timeout.** Stimulus: a fetch that the memory never acks. Required: `if_rvalid` with `if_rdata = 0` at cycle 2 + 255 = 257; `err` rises and stays high; a subsequent normal access still completes.
- **Async reset mid-access.** Stimulus: assert `rst` between clock edges while in BUSY. Required: `mem_req`, `stall`-relevant state and `err` go to 0 before the next edge; no `rvalid`; after release, a new request is served with minimum latency.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant owner and word width.
package mem_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Wait counter for an outstanding memory access; flags expiry once TIMEOUT busy cycles pass without an ack.
module mem_arb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    // Holds at the limit so an expired count can never wrap back into range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (i_clear) begin
            r_wait_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    assign o_expired = (r_wait_cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// serialising requests, generating the pipeline stall and a sticky timeout error.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [WORD_W-1:0] dm_addr,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic              dm_rvalid,
    output logic [WORD_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              stall,
    output logic              err
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    arb_owner_t          r_owner;
    arb_owner_t          w_grant_owner;
    logic                w_grant;
    logic                w_complete;
    logic                w_expired;
    logic [WORD_W-1:0]   w_resp_data;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [WORD_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic                r_if_rvalid;
    logic [WORD_W-1:0]   r_if_rdata;
    logic                r_dm_rvalid;
    logic [WORD_W-1:0]   r_dm_rdata;
    logic                r_err;

    mem_arb_timeout #(
        .TIMEOUT   (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_grant),
        .i_enable  (r_state == BUSY),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Data normally wins a contested grant; fetch wins once it has been passed over STARVE_LIMIT times.
    always_comb begin
        w_next_state  = r_state;
        w_grant       = 1'b0;
        w_grant_owner = OWN_DM;
        w_complete    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (if_req || dm_req) begin
                    w_grant      = 1'b1;
                    w_next_state = BUSY;
                    if (if_req && (!dm_req || r_starve_cnt == STARVE_W'(STARVE_LIMIT))) begin
                        w_grant_owner = OWN_IF;
                    end
                end
            end
            BUSY: begin
                if (mem_ack || w_expired) begin
                    w_complete   = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_resp_data = (mem_ack && !r_mem_we) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= OWN_IF;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rvalid  <= 1'b0;
            r_dm_rdata   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            if (w_grant) begin
                r_owner   <= w_grant_owner;
                r_mem_req <= 1'b1;
                if (w_grant_owner == OWN_IF) begin
                    r_mem_we     <= 1'b0;
                    r_mem_addr   <= if_addr;
                    r_mem_wdata  <= '0;
                    r_starve_cnt <= '0;
                end else begin
                    r_mem_we    <= dm_we;
                    r_mem_addr  <= dm_addr;
                    r_mem_wdata <= dm_wdata;
                    if (if_req && r_starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
                    end
                end
            end
            // A timed-out access still completes, with zero data and the error latched.
            if (w_complete) begin
                r_mem_req <= 1'b0;
                if (!mem_ack) begin
                    r_err <= 1'b1;
                end
                if (r_owner == OWN_IF) begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= w_resp_data;
                end else begin
                    r_dm_rvalid <= 1'b1;
                    r_dm_rdata  <= w_resp_data;
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_rvalid = r_dm_rvalid;
    assign dm_rdata  = r_dm_rdata;
    assign err       = r_err;
    assign stall     = (if_req & ~r_if_rvalid) | (dm_req & ~r_dm_rvalid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single accesses plus contention,
// starvation, timeout and asynchronous-reset sequences, checked through a response scoreboard.
module tb_mem_port_arbiter;

    localparam int TIMEOUT      = 255;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        err;

    mem_port_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isDm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ackDelay;
        bit          noAck;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        bit          isDm;
        logic [31:0] data;
    } resp_t;

    resp_t       sbQueue[$];
    logic [31:0] memModel [logic [31:0]];
    vec_t        vectors[7];
    int          ackDelay   = 0;
    bit          noAck      = 1'b0;
    int          busyCycles = 0;
    int          testCount  = 0;
    int          failCount  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input bit isDm, input logic [31:0] data);
        resp_t r;
        r.isDm = isDm;
        r.data = data;
        sbQueue.push_back(r);
    endtask

    task automatic scoreboardPop(input bit isDm, input logic [31:0] data);
        resp_t r;
        if (sbQueue.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL unexpected rvalid: owner dm=%0d data 0x%08h, expected no response", isDm, data);
        end else begin
            r = sbQueue.pop_front();
            checkOutput("response owner (1=dm)", 32'(isDm), 32'(r.isDm));
            checkOutput("response data", data, r.data);
        end
    endtask

    // Variable-latency memory: acks after ackDelay cycles of mem_req, or never when noAck is set.
    always @(negedge clk) begin
        if (mem_req && !noAck) begin
            if (busyCycles == ackDelay) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    memModel[mem_addr] = mem_wdata;
                    mem_rdata = 32'hBAD0_BAD0;
                end else begin
                    mem_rdata = memModel.exists(mem_addr) ? memModel[mem_addr] : 32'hFFFF_FFFF;
                end
            end else begin
                mem_ack = 1'b0;
            end
            busyCycles++;
        end else begin
            mem_ack    = 1'b0;
            busyCycles = 0;
        end
    end

    always @(negedge clk) begin
        if (if_rvalid) scoreboardPop(1'b0, if_rdata);
        if (dm_rvalid) scoreboardPop(1'b1, dm_rdata);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testCount, failCount + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input vec_t v);
        int cyc;
        bit seen;
        bit holdOk;
        @(posedge clk);
        #1;
        ackDelay = v.ackDelay;
        noAck    = v.noAck;
        if (v.isDm) begin
            dm_req   = 1'b1;
            dm_we    = v.we;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        pushExpect(v.isDm, v.expData);
        @(negedge clk);
        checkOutput("stall in request cycle", 32'(stall), 32'd1);
        checkOutput("mem_req low in request cycle", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("mem_req one cycle after request", 32'(mem_req), 32'd1);
        checkOutput("mem_addr at grant", mem_addr, v.addr);
        checkOutput("mem_we at grant", 32'(mem_we), 32'(v.we));
        if (v.we) checkOutput("mem_wdata at grant", mem_wdata, v.wdata);
        holdOk = 1'b1;
        seen   = 1'b0;
        cyc    = 1;
        while (!seen && cyc < 2 + TIMEOUT + 20) begin
            if (mem_req && (mem_addr !== v.addr || mem_we !== v.we)) holdOk = 1'b0;
            if (mem_req && v.we && mem_wdata !== v.wdata) holdOk = 1'b0;
            @(negedge clk);
            cyc++;
            seen = v.isDm ? dm_rvalid : if_rvalid;
        end
        checkOutput("rvalid cycle", 32'(cyc), 32'(2 + (v.noAck ? TIMEOUT : v.ackDelay)));
        checkOutput("mem_* stable while mem_req", 32'(holdOk), 32'd1);
        if (seen) checkOutput("stall low with rvalid", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        @(negedge clk);
        checkOutput("rvalid is a single-cycle pulse", 32'(v.isDm ? dm_rvalid : if_rvalid), 32'd0);
    endtask

    initial begin
        vec_t tv;
        int   cyc;
        int   dmDone;
        bit   ifSeen;

        memModel[32'h1000] = 32'h2402_000A;
        memModel[32'h1004] = 32'h2042_0001;
        memModel[32'h1008] = 32'h1111_1111;
        memModel[32'h2000] = 32'h8C43_0000;

        //            isDm we  addr          wdata          dly noAck expData
        vectors[0] = '{1'b0, 1'b0, 32'h1000, 32'h0,         0, 1'b0, 32'h2402_000A};
        vectors[1] = '{1'b1, 1'b0, 32'h2000, 32'h0,         1, 1'b0, 32'h8C43_0000};
        vectors[2] = '{1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 2, 1'b0, 32'h0};
        vectors[3] = '{1'b1, 1'b0, 32'h2004, 32'h0,         0, 1'b0, 32'hDEAD_BEEF};
        vectors[4] = '{1'b0, 1'b0, 32'h1004, 32'h0,         3, 1'b0, 32'h2042_0001};
        vectors[5] = '{1'b1, 1'b1, 32'h2008, 32'h1234_5678, 0, 1'b0, 32'h0};
        vectors[6] = '{1'b1, 1'b0, 32'h2008, 32'h0,         1, 1'b0, 32'h1234_5678};

        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset if_rvalid", 32'(if_rvalid), 32'd0);
        checkOutput("reset dm_rvalid", 32'(dm_rvalid), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vectors[i]);
        end

        // Both requesters raised together: data first, fetch follows after RESP and IDLE.
        @(posedge clk);
        #1;
        ackDelay = 0;
        noAck    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h1000;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h2000;
        pushExpect(1'b1, 32'h8C43_0000);
        pushExpect(1'b0, 32'h2402_000A);
        @(negedge clk);
        @(negedge clk);
        checkOutput("contested: dm served first", mem_addr, 32'h2000);
        @(negedge clk);
        checkOutput("contested: dm_rvalid cycle 2", 32'(dm_rvalid), 32'd1);
        checkOutput("contested: if still waiting", 32'(if_rvalid), 32'd0);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        @(negedge clk);
        checkOutput("contested: idle in cycle 3", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("contested: if mem_req cycle 4", 32'(mem_req), 32'd1);
        checkOutput("contested: if mem_addr cycle 4", mem_addr, 32'h1000);
        @(negedge clk);
        checkOutput("contested: if_rvalid cycle 5", 32'(if_rvalid), 32'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(posedge clk);

        // Data held continuously against a waiting fetch.
        #1;
        if_req  = 1'b1;
        if_addr = 32'h1004;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h2000;
        for (int i = 0; i < STARVE_LIMIT; i++) pushExpect(1'b1, 32'h8C43_0000);
        pushExpect(1'b0, 32'h2042_0001);
        dmDone = 0;
        ifSeen = 1'b0;
        cyc    = 0;
        while (!ifSeen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (dm_rvalid) dmDone++;
            if (if_rvalid) ifSeen = 1'b1;
        end
        checkOutput("starve: dm completions before if", 32'(dmDone), 32'd4);
        checkOutput("starve: if completion cycle", 32'(cyc - 1), 32'd14);
        checkOutput("starve: starve_cnt after if grant", 32'(dut.r_starve_cnt), 32'd0);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        @(posedge clk);

        checkOutput("err low before timeout", 32'(err), 32'd0);
        tv = '{1'b0, 1'b0, 32'h1008, 32'h0, 0, 1'b1, 32'h0};
        applyStimulus(tv);
        checkOutput("err set by timeout", 32'(err), 32'd1);
        applyStimulus(vectors[1]);
        checkOutput("err sticky after normal access", 32'(err), 32'd1);

        // Reset asserted between edges while an access is in BUSY.
        @(posedge clk);
        #1;
        ackDelay = 10;
        noAck    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h1000;
        pushExpect(1'b0, 32'h2402_000A);
        @(negedge clk);
        @(negedge clk);
        checkOutput("busy before async reset", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("async reset err", 32'(err), 32'd0);
        checkOutput("async reset if_rvalid", 32'(if_rvalid), 32'd0);
        sbQueue.delete();
        if_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(vectors[0]);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
